// File: rtl/psram_arb_pkg.sv
// Shared types and defaults for the PSRAM round-robin arbiter.
package psram_arb_pkg;

  localparam int unsigned DEF_ADDR_W = 22;
  localparam int unsigned DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ISSUE      = 2'd1,
    WAIT_START = 2'd2,
    WAIT_DONE  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/psram_arbiter_rr_pick.sv
// Rotate-priority encoder: first set request strictly after ptr, wrapping modulo NREQ.
module rr_pick #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  logic [IDX_W-1:0] cand;

  // Walk from the farthest candidate back to the nearest so the nearest wins.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int unsigned k = NREQ; k >= 1; k--) begin
      cand = IDX_W'((32'(ptr) + k) % NREQ);
      if (req[cand]) begin
        idx   = cand;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/psram_arbiter.sv
// Round-robin arbiter sharing one PSRAM controller among NREQ requesters.
// Define PSRAM_ARB_TIMEOUT_EN to enable the completion watchdog (err output).
module psram_arbiter
  import psram_arb_pkg::*;
#(
  parameter int unsigned NREQ           = 4,
  parameter int unsigned ADDR_W         = DEF_ADDR_W,
  parameter int unsigned DATA_W         = DEF_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        we,
  input  logic [NREQ-1:0]        byte_we,
  input  logic [NREQ*ADDR_W-1:0] addr,
  input  logic [NREQ*DATA_W-1:0] wdata,
  output logic [NREQ-1:0]        ack,
  output logic [DATA_W-1:0]      rdata,
  output logic                   err,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic                   mem_byte_write,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_din,
  input  logic [DATA_W-1:0]      mem_dout,
  input  logic                   mem_busy
);

  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_t       state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] idx_l;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_valid;
  logic             timed_out_c;

  logic [ADDR_W-1:0] addr_a  [NREQ];
  logic [DATA_W-1:0] wdata_a [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unflat
    assign addr_a[i]  = addr[i*ADDR_W +: ADDR_W];
    assign wdata_a[i] = wdata[i*DATA_W +: DATA_W];
  end

  rr_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

`ifdef PSRAM_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wd_cnt;

  // Counts cycles spent waiting for the controller to finish.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wd_cnt <= '0;
    end else if (state == WAIT_START || state == WAIT_DONE) begin
      wd_cnt <= wd_cnt + CNT_W'(1);
    end else begin
      wd_cnt <= '0;
    end
  end

  assign timed_out_c = (state == WAIT_DONE) && mem_busy &&
                       (wd_cnt >= CNT_W'(TIMEOUT_CYCLES - 1));
`else
  // Watchdog compiled out: completion waits on mem_busy alone.
  assign timed_out_c = (TIMEOUT_CYCLES == 0) & 1'b0;
`endif

  // Transaction sequencer; command and response outputs are registered here.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= IDLE;
      ptr            <= IDX_W'(NREQ - 1);
      idx_l          <= '0;
      ack            <= '0;
      rdata          <= '0;
      err            <= 1'b0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_byte_write <= 1'b0;
      mem_addr       <= '0;
      mem_din        <= '0;
    end else begin
      ack       <= '0;
      err       <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid && !mem_busy) begin
            idx_l          <= pick_idx;
            mem_read       <= ~we[pick_idx];
            mem_write      <= we[pick_idx];
            mem_byte_write <= byte_we[pick_idx];
            mem_addr       <= addr_a[pick_idx];
            mem_din        <= wdata_a[pick_idx];
            state          <= ISSUE;
          end
        end
        ISSUE:      state <= WAIT_START;
        // Controller raises busy only the cycle after the command.
        WAIT_START: state <= WAIT_DONE;
        WAIT_DONE: begin
          if (!mem_busy || timed_out_c) begin
            rdata          <= timed_out_c ? '0 : mem_dout;
            err            <= timed_out_c;
            ack[idx_l]     <= 1'b1;
            ptr            <= idx_l;
            mem_byte_write <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psram_arbiter.sv
// Self-checking bench for psram_arbiter: directed scenarios plus randomized rounds
// against a requester-level memory/rotation model; the bench also plays the controller.
module tb_psram_arbiter;

  localparam int unsigned NREQ      = 4;
  localparam int unsigned ADDR_W    = 22;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned MEM_WORDS = 256;

  logic                   clk;
  logic                   resetn;
  logic [NREQ-1:0]        req, we, byte_we, ack;
  logic [NREQ*ADDR_W-1:0] addr;
  logic [NREQ*DATA_W-1:0] wdata;
  logic [DATA_W-1:0]      rdata, mem_din, mem_dout;
  logic [ADDR_W-1:0]      mem_addr;
  logic                   err, mem_read, mem_write, mem_byte_write, mem_busy;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int ptr_m;
  int last_cmd_wait;

  logic [15:0]       ref_mem [0:MEM_WORDS-1];
  logic [15:0]       ctl_mem [0:MEM_WORDS-1];
  logic [ADDR_W-1:0] op_addr  [NREQ];
  logic [15:0]       op_wdata [NREQ];
  logic              op_we    [NREQ];
  logic              op_bw    [NREQ];

  psram_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .resetn(resetn), .req(req), .we(we), .byte_we(byte_we), .addr(addr),
    .wdata(wdata), .ack(ack), .rdata(rdata), .err(err), .mem_read(mem_read),
    .mem_write(mem_write), .mem_byte_write(mem_byte_write), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_busy(mem_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench did not finish");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int next_grant(input logic [NREQ-1:0] pend, input int p);
    for (int k = 1; k <= NREQ; k++) begin
      if (pend[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return 0;
  endfunction

  task automatic set_op(input int i, input logic w, input logic bw,
                        input logic [ADDR_W-1:0] a, input logic [15:0] d);
    op_we[i] = w; op_bw[i] = bw; op_addr[i] = a; op_wdata[i] = d;
    we[i] = w;
    byte_we[i] = bw;
    addr[i*ADDR_W +: ADDR_W] = a;
    wdata[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic rand_op(input int i);
    set_op(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ADDR_W'($urandom_range(0, 2 * MEM_WORDS - 1)), 16'($urandom));
  endtask

  task automatic ref_write(input int i);
    int w;
    w = int'(op_addr[i][8:1]);
    if (!op_bw[i]) ref_mem[w] = op_wdata[i];
    else if (op_addr[i][0]) ref_mem[w][15:8] = op_wdata[i][15:8];
    else ref_mem[w][7:0] = op_wdata[i][7:0];
  endtask

  // Acts as the controller for one transaction and checks the requester-visible result.
  task automatic serve(input int exp_idx, input int lat);
    int          waitc;
    int          wi;
    logic [15:0] dout_v;
    logic [15:0] exp_r;
    waitc = 0;
    while (!(mem_read || mem_write) && waitc < 300) begin
      @(negedge clk);
      waitc++;
    end
    last_cmd_wait = waitc;
    chk("cmd_seen", 32'(mem_read | mem_write), 32'd1);
    chk("cmd_is_write", 32'(mem_write), 32'(op_we[exp_idx]));
    chk("cmd_addr", 32'(mem_addr), 32'(op_addr[exp_idx]));
    if (op_we[exp_idx]) begin
      chk("cmd_din", 32'(mem_din), 32'(op_wdata[exp_idx]));
      chk("cmd_byte_write", 32'(mem_byte_write), 32'(op_bw[exp_idx]));
    end
    wi = int'(mem_addr[8:1]);
    if (mem_write) begin
      if (!mem_byte_write) ctl_mem[wi] = mem_din;
      else if (mem_addr[0]) ctl_mem[wi][15:8] = mem_din[15:8];
      else ctl_mem[wi][7:0] = mem_din[7:0];
      dout_v = 16'($urandom);
    end else begin
      dout_v = ctl_mem[wi];
    end
    mem_busy = 1'b1;
    @(negedge clk);
    chk("cmd_one_cycle", 32'(mem_read | mem_write), 32'd0);
    for (int c = 1; c < lat; c++) @(negedge clk);
    chk("addr_held", 32'(mem_addr), 32'(op_addr[exp_idx]));
    mem_busy = 1'b0;
    mem_dout = dout_v;
    if (op_we[exp_idx]) begin
      ref_write(exp_idx);
      exp_r = dout_v;
    end else begin
      exp_r = ref_mem[int'(op_addr[exp_idx][8:1])];
    end
    waitc = 0;
    do begin
      @(negedge clk);
      waitc++;
    end while (ack == '0 && waitc < 50);
    chk("ack_latency", 32'(waitc), 32'd1);
    chk("ack_vec", 32'(ack), 32'd1 << exp_idx);
    chk("rdata", 32'(rdata), 32'(exp_r));
    chk("err", 32'(err), 32'd0);
    ptr_m = exp_idx;
    mem_dout = 16'($urandom);
  endtask

  initial begin
    int cnt;
    int g;
    int n;
    resetn = 1'b0; req = '0; we = '0; byte_we = '0; addr = '0; wdata = '0;
    mem_busy = 1'b1; mem_dout = '0;
    for (int i = 0; i < int'(MEM_WORDS); i++) begin
      ref_mem[i] = 16'($urandom);
      ctl_mem[i] = ref_mem[i];
    end
    for (int i = 0; i < int'(NREQ); i++) set_op(i, 1'b0, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_cmd", 32'({mem_read, mem_write, mem_byte_write}), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_din", 32'(mem_din), 32'd0);
    resetn = 1'b1;
    ptr_m = NREQ - 1;

    // Controller still initialising: no grant while busy.
    set_op(0, 1'b0, 1'b0, 22'h10, 16'h0);
    req = 4'b0001;
    cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (mem_read || mem_write) cnt++;
    end
    chk("no_cmd_while_busy", 32'(cnt), 32'd0);
    mem_busy = 1'b0;
    serve(0, 3);
    chk("cmd_latency_after_busy", 32'(last_cmd_wait), 32'd1);
    req = '0;

    // Byte write from requester 2.
    set_op(2, 1'b1, 1'b1, 22'h00123, 16'hA5A5);
    req = 4'b0100;
    serve(2, 4);
    req = '0;

    // Read with known data, then hold check.
    ref_mem[32'h20] = 16'hBEEF;
    ctl_mem[32'h20] = 16'hBEEF;
    set_op(1, 1'b0, 1'b0, 22'h40, 16'h0);
    req = 4'b0010;
    serve(1, 5);
    chk("rdata_beef", 32'(rdata), 32'hBEEF);
    req = '0;
    repeat (5) @(negedge clk);
    chk("rdata_hold", 32'(rdata), 32'hBEEF);

    // Fairness from a fresh pointer with everyone requesting.
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    ptr_m = NREQ - 1;
    for (int i = 0; i < int'(NREQ); i++) rand_op(i);
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      serve(k % NREQ, 2 + int'($urandom_range(0, 3)));
      rand_op(k % NREQ);
    end
    req = '0;

    // Reset while waiting for completion.
    set_op(1, 1'b0, 1'b0, 22'h0A, 16'h0);
    req = 4'b0010;
    cnt = 0;
    while (!mem_read && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    chk("midrst_cmd_seen", 32'(mem_read), 32'd1);
    mem_busy = 1'b1;
    repeat (2) @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("midrst_outputs", 32'({ack, err, mem_read, mem_write, mem_byte_write}), 32'd0);
    chk("midrst_addr", 32'(mem_addr), 32'd0);
    chk("midrst_rdata", 32'(rdata), 32'd0);
    mem_busy = 1'b0;
    rand_op(0);
    rand_op(3);
    req = 4'b1001;
    cnt = 0;
    repeat (2) begin
      @(negedge clk);
      if (ack != '0) cnt++;
    end
    chk("midrst_no_ack", 32'(cnt), 32'd0);
    resetn = 1'b1;
    ptr_m = NREQ - 1;
    serve(0, 3);
    req[0] = 1'b0;
    serve(3, 2);
    req = '0;

    // Randomized rounds against the rotation/memory model.
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < int'(NREQ); i++) rand_op(i);
      req = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      n = 0;
      while (req != '0 && n < 40) begin
        g = next_grant(req, ptr_m);
        serve(g, 2 + int'($urandom_range(0, 5)));
        if ($urandom_range(0, 2) == 0) rand_op(g);
        else req[g] = 1'b0;
        n++;
      end
      req = '0;
      repeat (int'($urandom_range(0, 3))) @(negedge clk);
    end

`ifdef PSRAM_ARB_TIMEOUT_EN
    // Controller never completes: watchdog acks with err.
    set_op(2, 1'b0, 1'b0, 22'h30, 16'h0);
    req = 4'b0100;
    cnt = 0;
    while (!mem_read && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    chk("to_cmd_seen", 32'(mem_read), 32'd1);
    mem_busy = 1'b1;
    cnt = 0;
    while (ack == '0 && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    chk("to_ack_vec", 32'(ack), 32'b0100);
    chk("to_err", 32'(err), 32'd1);
    chk("to_rdata", 32'(rdata), 32'd0);
    ptr_m = 2;
    req = 4'b0001;
    set_op(0, 1'b0, 1'b0, 22'h32, 16'h0);
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (mem_read || mem_write) cnt++;
    end
    chk("to_no_grant_busy", 32'(cnt), 32'd0);
    mem_busy = 1'b0;
    serve(0, 3);
    req = '0;
`endif

    cnt = 0;
    for (int i = 0; i < int'(MEM_WORDS); i++) if (ctl_mem[i] !== ref_mem[i]) cnt++;
    chk("mem_consistent", 32'(cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
